// File: rtl/bcd_clock_ctrl.sv
// HH:MM BCD time-keeping controller: minute prescaler, ripple-carry digit counter,
// and a RUN / SET_HR / SET_MIN mode machine with a blinking field enable.
module bcd_clock_ctrl #(
    parameter int TICKS_PER_MIN = 6000,
    parameter int BLINK_DIV     = 50
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] ms_hour,
    output logic [3:0] ls_hour,
    output logic [3:0] ms_min,
    output logic [3:0] ls_min,
    output logic       add_one,
    output logic [1:0] mode,
    output logic       blink
);

    localparam int PW = $clog2(TICKS_PER_MIN);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_MIN - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        MODE_RUN     = 2'd0,
        MODE_SET_HR  = 2'd1,
        MODE_SET_MIN = 2'd2
    } mode_e;

    mode_e         mode_q, mode_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_q, blink_d;
    logic          add_one_q, add_one_d;
    logic [3:0]    hr_t_q, hr_t_d, hr_u_q, hr_u_d;
    logic [3:0]    mn_t_q, mn_t_d, mn_u_q, mn_u_d;

    // Incremented field values; min_carry flags the 59 -> 00 rollover.
    logic [3:0] hr_t_inc, hr_u_inc, mn_t_inc, mn_u_inc;
    logic       min_carry;

    always_comb begin
        mn_u_inc  = mn_u_q + 4'd1;
        mn_t_inc  = mn_t_q;
        min_carry = 1'b0;
        if (mn_u_q == 4'd9) begin
            mn_u_inc = 4'd0;
            if (mn_t_q == 4'd5) begin
                mn_t_inc  = 4'd0;
                min_carry = 1'b1;
            end else begin
                mn_t_inc = mn_t_q + 4'd1;
            end
        end

        hr_u_inc = hr_u_q + 4'd1;
        hr_t_inc = hr_t_q;
        if (hr_t_q == 4'd2 && hr_u_q == 4'd3) begin
            hr_u_inc = 4'd0;
            hr_t_inc = 4'd0;
        end else if (hr_u_q == 4'd9) begin
            hr_u_inc = 4'd0;
            hr_t_inc = hr_t_q + 4'd1;
        end
    end

    always_comb begin
        mode_d      = mode_q;
        presc_d     = presc_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        add_one_d   = 1'b0;
        hr_t_d      = hr_t_q;
        hr_u_d      = hr_u_q;
        mn_t_d      = mn_t_q;
        mn_u_d      = mn_u_q;

        case (mode_q)
            MODE_RUN: begin
                if (presc_q == PRESC_MAX) begin
                    presc_d   = '0;
                    add_one_d = 1'b1;
                    mn_u_d    = mn_u_inc;
                    mn_t_d    = mn_t_inc;
                    if (min_carry) begin
                        hr_u_d = hr_u_inc;
                        hr_t_d = hr_t_inc;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
                if (btn_mode) begin
                    mode_d      = MODE_SET_HR;
                    presc_d     = '0;
                    blink_d     = 1'b1;
                    blink_cnt_d = '0;
                end
            end

            MODE_SET_HR, MODE_SET_MIN: begin
                presc_d = '0;
                if (blink_cnt_q == BLINK_MAX) begin
                    blink_cnt_d = '0;
                    blink_d     = ~blink_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + 1'b1;
                end

                if (btn_mode) begin
                    if (mode_q == MODE_SET_HR) begin
                        mode_d = MODE_SET_MIN;
                    end else begin
                        mode_d      = MODE_RUN;
                        blink_d     = 1'b1;
                        blink_cnt_d = '0;
                    end
                end else if (btn_inc) begin
                    // Set modes wrap within their own field; no carry across.
                    if (mode_q == MODE_SET_HR) begin
                        hr_u_d = hr_u_inc;
                        hr_t_d = hr_t_inc;
                    end else begin
                        mn_u_d = mn_u_inc;
                        mn_t_d = mn_t_inc;
                    end
                end
            end

            default: begin
                mode_d      = MODE_RUN;
                presc_d     = '0;
                blink_d     = 1'b1;
                blink_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q      <= MODE_RUN;
            presc_q     <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b1;
            add_one_q   <= 1'b0;
            hr_t_q      <= 4'd0;
            hr_u_q      <= 4'd0;
            mn_t_q      <= 4'd0;
            mn_u_q      <= 4'd0;
        end else begin
            mode_q      <= mode_d;
            presc_q     <= presc_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            add_one_q   <= add_one_d;
            hr_t_q      <= hr_t_d;
            hr_u_q      <= hr_u_d;
            mn_t_q      <= mn_t_d;
            mn_u_q      <= mn_u_d;
        end
    end

    assign ms_hour = hr_t_q;
    assign ls_hour = hr_u_q;
    assign ms_min  = mn_t_q;
    assign ls_min  = mn_u_q;
    assign add_one = add_one_q;
    assign mode    = mode_q;
    assign blink   = blink_q;

endmodule

// File: tb/tb_bcd_clock_ctrl.sv
// Directed bench for bcd_clock_ctrl with TICKS_PER_MIN=4, BLINK_DIV=2; expected
// time values come from a small hour/minute model kept in the bench.
module tb_bcd_clock_ctrl;

    localparam int TPM = 4;
    localparam int BD  = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       btn_mode;
    logic       btn_inc;
    logic [3:0] ms_hour, ls_hour, ms_min, ls_min;
    logic       add_one;
    logic [1:0] mode;
    logic       blink;
    logic [15:0] time_now;

    int n_vec = 0;
    int n_err = 0;
    int exp_hr = 0;
    int exp_mn = 0;
    int add_one_cnt = 0;
    int snap;

    bcd_clock_ctrl #(.TICKS_PER_MIN(TPM), .BLINK_DIV(BD)) dut (
        .clk(clk), .reset_n(reset_n), .btn_mode(btn_mode), .btn_inc(btn_inc),
        .ms_hour(ms_hour), .ls_hour(ls_hour), .ms_min(ms_min), .ls_min(ls_min),
        .add_one(add_one), .mode(mode), .blink(blink)
    );

    always #5 clk = ~clk;

    assign time_now = {ms_hour, ls_hour, ms_min, ls_min};

    always @(posedge clk) begin
        #1;
        if (add_one) add_one_cnt++;
    end

    function automatic logic [15:0] bcd(input int h, input int m);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10)};
    endfunction

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("  ok %s = %h", tag, got);
        end
    endtask

    task automatic pulse_mode(input int exp_mode);
        btn_mode = 1'b1;
        @(negedge clk);
        btn_mode = 1'b0;
        check_val("mode_step", 16'(mode), 16'(exp_mode));
    endtask

    task automatic inc_pulses(input int n);
        if (n > 0) begin
            btn_inc = 1'b1;
            repeat (n) @(negedge clk);
            btn_inc = 1'b0;
        end
    endtask

    // Expects prescaler at 0 in RUN; checks a full minute then the tick.
    task automatic run_tick(input string tag);
        for (int i = 1; i <= TPM; i++) begin
            @(negedge clk);
            if (i < TPM) begin
                check_val({tag, "_idle_add"}, 16'(add_one), 16'd0);
                check_val({tag, "_idle_time"}, time_now, bcd(exp_hr, exp_mn));
            end else begin
                exp_mn++;
                if (exp_mn == 60) begin
                    exp_mn = 0;
                    exp_hr = (exp_hr + 1) % 24;
                end
                check_val({tag, "_tick_add"}, 16'(add_one), 16'd1);
                check_val({tag, "_tick_time"}, time_now, bcd(exp_hr, exp_mn));
            end
        end
    endtask

    task automatic set_time(input int h, input int m, input bit stay_in_min);
        pulse_mode(1);
        inc_pulses((h - exp_hr + 24) % 24);
        exp_hr = h;
        pulse_mode(2);
        inc_pulses((m - exp_mn + 60) % 60);
        exp_mn = m;
        if (!stay_in_min) pulse_mode(0);
        check_val("set_time", time_now, bcd(exp_hr, exp_mn));
    endtask

    initial begin
        reset_n  = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_time", time_now, 16'h0000);
        check_val("rst_mode", 16'(mode), 16'd0);
        check_val("rst_add_one", 16'(add_one), 16'd0);
        check_val("rst_blink", 16'(blink), 16'd1);
        reset_n = 1'b1;

        // First tick at edge TPM, then one per TPM edges.
        run_tick("first");
        @(negedge clk);
        check_val("add_one_single", 16'(add_one), 16'd0);
        repeat (7) @(negedge clk);
        check_val("time_0003", time_now, 16'h0003);
        exp_mn = 3;

        set_time(0, 59, 1'b0);
        run_tick("carry_0059");
        set_time(9, 59, 1'b0);
        run_tick("carry_0959");
        set_time(23, 59, 1'b0);
        run_tick("carry_2359");

        // SET_HR entry: blink pattern 1,1,0,0,1 and wrap through 24 increments.
        snap = add_one_cnt;
        pulse_mode(1);
        check_val("blink_e0", 16'(blink), 16'd1);
        @(negedge clk); check_val("blink_e1", 16'(blink), 16'd1);
        @(negedge clk); check_val("blink_e2", 16'(blink), 16'd0);
        @(negedge clk); check_val("blink_e3", 16'(blink), 16'd0);
        @(negedge clk); check_val("blink_e4", 16'(blink), 16'd1);
        inc_pulses(5);
        exp_hr = 5;
        check_val("hr_to_05", time_now, bcd(exp_hr, exp_mn));
        inc_pulses(24);
        check_val("hr_wrap24", time_now, bcd(exp_hr, exp_mn));
        pulse_mode(2);
        inc_pulses(59);
        exp_mn = 59;
        check_val("min_to_59", time_now, bcd(exp_hr, exp_mn));
        inc_pulses(1);
        exp_mn = 0;
        check_val("min_wrap", time_now, bcd(exp_hr, exp_mn));
        pulse_mode(0);
        check_val("blink_run", 16'(blink), 16'd1);
        check_val("no_add_in_set", 16'(add_one_cnt), 16'(snap));

        // Button priority and btn_inc ignored in RUN.
        set_time(12, 34, 1'b0);
        btn_inc = 1'b1;
        @(negedge clk);
        btn_inc = 1'b0;
        check_val("inc_in_run_time", time_now, 16'h1234);
        check_val("inc_in_run_mode", 16'(mode), 16'd0);
        btn_mode = 1'b1;
        btn_inc  = 1'b1;
        @(negedge clk);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        check_val("both_mode", 16'(mode), 16'd1);
        check_val("both_time", time_now, 16'h1234);
        pulse_mode(2);
        pulse_mode(0);
        run_tick("after_set");

        // Prescaler restart after a partial minute.
        repeat (2) @(negedge clk);
        check_val("partial_add", 16'(add_one), 16'd0);
        pulse_mode(1);
        pulse_mode(2);
        pulse_mode(0);
        run_tick("restart");

        // Asynchronous reset between clock edges while in SET_MIN.
        set_time(17, 42, 1'b1);
        check_val("pre_rst_mode", 16'(mode), 16'd2);
        #1 reset_n = 1'b0;
        #1;
        check_val("async_time", time_now, 16'h0000);
        check_val("async_mode", 16'(mode), 16'd0);
        check_val("async_blink", 16'(blink), 16'd1);
        check_val("async_add_one", 16'(add_one), 16'd0);
        #1 reset_n = 1'b1;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
